// File: rtl/int_ctrl_pkg.sv
// Shared types and CP0 register indices for the interrupt controller.
// Imported by int_ctrl and irq_prio_enc.
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        MASK,
        VECTOR,
        SERVICE,
        RETURN
    } state_t;

    localparam logic [1:0] CP0_IE  = 2'd0;
    localparam logic [1:0] CP0_INM = 2'd1;
    localparam logic [1:0] CP0_EPC = 2'd2;

    localparam int IRQ_ID_W = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over an N-bit request vector.
// Latency: combinational. Backpressure: none.
// Flow control: pure function of req; vld is low when no bit is set.
module irq_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]          req,
    output logic                  vld,
    output logic [IRQ_ID_W-1:0]   id
);

    always_comb begin
        vld = |req;
        id  = '0;
        // Walk downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched requests, IE/INM gating, CP0 entry/ERET sequencing.
// Latency: decision at inst_done, EPC/IE writes and redirect on the next three cycles; ERET one cycle.
// Backpressure: stall held for SAVE/MASK/VECTOR; optional nesting via INT_NESTING_EN.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ       = 3,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0800,
    parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0100
) (
    input  logic               in_CLK,
    input  logic               in_RST_N,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               ie,
    input  logic [NUM_IRQ-1:0] inm,
    input  logic [31:0]        epc,
    input  logic [31:0]        pc_in,
    input  logic               inst_done,
    input  logic               eret,
    output logic               cp0_we,
    output logic [1:0]         cp0_rw,
    output logic [31:0]        cp0_w,
    output logic               pc_redirect,
    output logic [31:0]        pc_target,
    output logic               stall,
    output logic [NUM_IRQ-1:0] in_service
);

    state_t                state_q, state_d;
    logic [NUM_IRQ-1:0]    irq_q;
    logic [NUM_IRQ-1:0]    pending_q;
    logic [NUM_IRQ-1:0]    svc_q;
    logic [IRQ_ID_W-1:0]   id_q;
    logic [31:0]           pc_q;

    logic                  req_vld;
    logic [IRQ_ID_W-1:0]   req_id;
    logic                  svc_vld;
    logic [IRQ_ID_W-1:0]   svc_id;
    logic                  take;
    logic                  nest_take;
    logic [NUM_IRQ-1:0]    id_oh;
    logic [NUM_IRQ-1:0]    svc_oh;
    logic [NUM_IRQ-1:0]    pend_clr;

    irq_prio_enc #(.N(NUM_IRQ)) u_req_enc (
        .req (pending_q & ~inm),
        .vld (req_vld),
        .id  (req_id)
    );

    irq_prio_enc #(.N(NUM_IRQ)) u_svc_enc (
        .req (svc_q),
        .vld (svc_vld),
        .id  (svc_id)
    );

    assign take   = req_vld & ie & inst_done;
    assign id_oh  = NUM_IRQ'(1) << id_q;
    assign svc_oh = NUM_IRQ'(1) << svc_id;

`ifdef INT_NESTING_EN
    // Only a strictly higher-priority source may preempt the running handlers.
    assign nest_take = take & (~svc_vld | (req_id < svc_id));
`else
    assign nest_take = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = SAVE;
                end else if (eret) begin
                    state_d = RETURN;
                end
            end
            SAVE:    state_d = MASK;
            MASK:    state_d = VECTOR;
            VECTOR:  state_d = SERVICE;
            SERVICE: begin
                if (eret) begin
                    state_d = RETURN;
                end else if (nest_take) begin
                    state_d = SAVE;
                end
            end
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pend_clr = (state_q == VECTOR) ? id_oh : '0;

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            svc_q     <= '0;
            id_q      <= '0;
            pc_q      <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq;
            // A fresh edge on the bit being acknowledged must survive the clear.
            pending_q <= (pending_q & ~pend_clr) | (irq & ~irq_q);
            if (state_d == SAVE) begin
                id_q <= req_id;
                pc_q <= pc_in;
            end
            if (state_q == VECTOR) begin
`ifdef INT_NESTING_EN
                svc_q <= svc_q | id_oh;
`else
                svc_q <= id_oh;
`endif
            end else if (state_q == RETURN && svc_vld) begin
                svc_q <= svc_q & ~svc_oh;
            end
        end
    end

    always_comb begin
        cp0_we      = 1'b0;
        cp0_rw      = CP0_IE;
        cp0_w       = '0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        stall       = 1'b0;
        case (state_q)
            SAVE: begin
                cp0_we = 1'b1;
                cp0_rw = CP0_EPC;
                cp0_w  = pc_q;
                stall  = 1'b1;
            end
            MASK: begin
                cp0_we = 1'b1;
                cp0_rw = CP0_IE;
                stall  = 1'b1;
            end
            VECTOR: begin
                pc_redirect = 1'b1;
                pc_target   = VECTOR_BASE + 32'(id_q) * VECTOR_STRIDE;
                stall       = 1'b1;
            end
            RETURN: begin
                cp0_we      = 1'b1;
                cp0_rw      = CP0_IE;
                cp0_w       = 32'd1;
                pc_redirect = 1'b1;
                pc_target   = epc;
            end
            default: ;
        endcase
    end

    assign in_service = svc_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed, table-driven bench for int_ctrl (NUM_IRQ=3, vectors 0x800 + id*0x100).
// Covers both builds; the preemption sequence depends on INT_NESTING_EN.
module tb_int_ctrl;

    logic        in_CLK = 1'b0;
    logic        in_RST_N;
    logic [2:0]  irq, inm, in_service;
    logic        ie, inst_done, eret;
    logic [31:0] epc, pc_in, cp0_w, pc_target;
    logic        cp0_we, pc_redirect, stall;
    logic [1:0]  cp0_rw;

    int n_cmp = 0;
    int n_bad = 0;

    int_ctrl #(.NUM_IRQ(3), .VECTOR_BASE(32'h800), .VECTOR_STRIDE(32'h100)) dut (
        .in_CLK(in_CLK), .in_RST_N(in_RST_N), .irq(irq), .ie(ie), .inm(inm),
        .epc(epc), .pc_in(pc_in), .inst_done(inst_done), .eret(eret),
        .cp0_we(cp0_we), .cp0_rw(cp0_rw), .cp0_w(cp0_w), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .stall(stall), .in_service(in_service)
    );

    always #5 in_CLK = ~in_CLK;

    // {we, rw, w, redirect, target, stall, in_service}
    typedef logic [71:0] exp_t;
    typedef struct {
        logic [2:0]  irq;
        logic        ie;
        logic [2:0]  inm;
        logic [31:0] epc;
        logic [31:0] pc;
        logic        done;
        logic        eret;
        exp_t        exp;
    } vec_t;

    exp_t act;
    assign act = {cp0_we, cp0_rw, cp0_w, pc_redirect, pc_target, stall, in_service};

    function automatic exp_t e_idle(input logic [2:0] s);
        return {1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, s};
    endfunction
    function automatic exp_t e_save(input logic [31:0] w, input logic [2:0] s);
        return {1'b1, 2'd2, w, 1'b0, 32'd0, 1'b1, s};
    endfunction
    function automatic exp_t e_mask(input logic [2:0] s);
        return {1'b1, 2'd0, 32'd0, 1'b0, 32'd0, 1'b1, s};
    endfunction
    function automatic exp_t e_vec(input logic [31:0] t, input logic [2:0] s);
        return {1'b0, 2'd0, 32'd0, 1'b1, t, 1'b1, s};
    endfunction
    function automatic exp_t e_ret(input logic [31:0] t, input logic [2:0] s);
        return {1'b1, 2'd0, 32'd1, 1'b1, t, 1'b0, s};
    endfunction

    function automatic vec_t mk(input logic [2:0] i, input logic e, input logic [2:0] m,
                                input logic [31:0] ep, input logic [31:0] p,
                                input logic d, input logic r, input exp_t x);
        vec_t v;
        v.irq = i; v.ie = e; v.inm = m; v.epc = ep; v.pc = p;
        v.done = d; v.eret = r; v.exp = x;
        return v;
    endfunction

    task automatic check(input exp_t want, input string nm);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge in_CLK);
        irq = v.irq; ie = v.ie; inm = v.inm; epc = v.epc;
        pc_in = v.pc; inst_done = v.done; eret = v.eret;
        @(posedge in_CLK);
        #1;
        check(v.exp, nm);
    endtask

    vec_t tbl[$];
    vec_t seq[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_RST_N = 1'b0;
        irq = '0; ie = 1'b0; inm = '0; epc = '0; pc_in = '0; inst_done = 1'b0; eret = 1'b0;
        #1;
        check(e_idle(3'b000), "reset");
        repeat (2) @(negedge in_CLK);
        in_RST_N = 1'b1;

        // Single source 1 entry and return.
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        tbl.push_back(mk(3'b010, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        tbl.push_back(mk(3'b010, 1, 3'b000, 0, 32'h40, 1, 0, e_save(32'h40, 3'b000)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_mask(3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_vec(32'h900, 3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_idle(3'b010)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 32'h44, 0, 0, 1, e_ret(32'h44, 3'b010)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        // Sources 2 and 0 together: 0 first, 2 stays pending.
        tbl.push_back(mk(3'b101, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        tbl.push_back(mk(3'b101, 1, 3'b000, 0, 32'h80, 1, 0, e_save(32'h80, 3'b000)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_mask(3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_vec(32'h800, 3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_idle(3'b001)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 32'h84, 0, 0, 1, e_ret(32'h84, 3'b001)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 32'h88, 1, 0, e_save(32'h88, 3'b000)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_mask(3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_vec(32'hA00, 3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_idle(3'b100)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 32'h8C, 0, 0, 1, e_ret(32'h8C, 3'b100)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        // Masked source stays pending, fires once unmasked.
        tbl.push_back(mk(3'b001, 1, 3'b001, 0, 0, 0, 0, e_idle(3'b000)));
        tbl.push_back(mk(3'b001, 1, 3'b001, 0, 0, 1, 0, e_idle(3'b000)));
        tbl.push_back(mk(3'b001, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 32'hC0, 1, 0, e_save(32'hC0, 3'b000)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_mask(3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_vec(32'h800, 3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_idle(3'b001)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 32'hC4, 0, 0, 1, e_ret(32'hC4, 3'b001)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        // IE low blocks entry until it rises.
        tbl.push_back(mk(3'b010, 0, 3'b000, 0, 0, 1, 0, e_idle(3'b000)));
        tbl.push_back(mk(3'b010, 0, 3'b000, 0, 0, 1, 0, e_idle(3'b000)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 32'hD0, 1, 0, e_save(32'hD0, 3'b000)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_mask(3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_vec(32'h900, 3'b000)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_idle(3'b010)));
        tbl.push_back(mk(3'b000, 0, 3'b000, 32'hD4, 0, 0, 1, e_ret(32'hD4, 3'b010)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        // ERET from IDLE.
        tbl.push_back(mk(3'b000, 1, 3'b000, 32'h50, 0, 0, 1, e_ret(32'h50, 3'b000)));
        tbl.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Reset asserted during MASK aborts the sequence and drops pending.
        apply(mk(3'b010, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)), "rst_edge");
        apply(mk(3'b010, 1, 3'b000, 0, 32'h60, 1, 0, e_save(32'h60, 3'b000)), "rst_save");
        apply(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_mask(3'b000)), "rst_mask");
        #1;
        in_RST_N = 1'b0;
        #1;
        check(e_idle(3'b000), "rst_abort");
        repeat (2) @(negedge in_CLK);
        in_RST_N = 1'b1;
        apply(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)), "rst_no_vector");
        apply(mk(3'b000, 1, 3'b000, 0, 32'h70, 1, 0, e_idle(3'b000)), "rst_pend_clear");

        // Service source 2, then source 0 arrives while in SERVICE.
        seq.push_back(mk(3'b100, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        seq.push_back(mk(3'b100, 1, 3'b000, 0, 32'h100, 1, 0, e_save(32'h100, 3'b000)));
        seq.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_mask(3'b000)));
        seq.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_vec(32'hA00, 3'b000)));
        seq.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_idle(3'b100)));
        seq.push_back(mk(3'b001, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b100)));
`ifdef INT_NESTING_EN
        seq.push_back(mk(3'b001, 1, 3'b000, 0, 32'h200, 1, 0, e_save(32'h200, 3'b100)));
        seq.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_mask(3'b100)));
        seq.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_vec(32'h800, 3'b100)));
        seq.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_idle(3'b101)));
        seq.push_back(mk(3'b000, 0, 3'b000, 32'h204, 0, 0, 1, e_ret(32'h204, 3'b101)));
        seq.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_idle(3'b100)));
        seq.push_back(mk(3'b000, 0, 3'b000, 32'h104, 0, 0, 1, e_ret(32'h104, 3'b100)));
        seq.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
`else
        seq.push_back(mk(3'b001, 1, 3'b000, 0, 32'h200, 1, 0, e_idle(3'b100)));
        seq.push_back(mk(3'b000, 1, 3'b000, 32'h104, 32'h204, 1, 1, e_ret(32'h104, 3'b100)));
        seq.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
        seq.push_back(mk(3'b000, 1, 3'b000, 0, 32'h110, 1, 0, e_save(32'h110, 3'b000)));
        seq.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_mask(3'b000)));
        seq.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_vec(32'h800, 3'b000)));
        seq.push_back(mk(3'b000, 0, 3'b000, 0, 0, 0, 0, e_idle(3'b001)));
        seq.push_back(mk(3'b000, 0, 3'b000, 32'h114, 0, 0, 1, e_ret(32'h114, 3'b001)));
        seq.push_back(mk(3'b000, 1, 3'b000, 0, 0, 0, 0, e_idle(3'b000)));
`endif
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i], $sformatf("svc_seq[%0d]", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
